sample_buf_reader: RTL
======================

Name: sample_buf_reader

Overview:
- Read-side counterpart of the microphone capture block.
- Requests a capture, waits for the buffer-filled pulse, then reads the DEPTH-entry sample RAM in ascending address order. The capture side stores samples bit-reversed, so ascending reads yield bit-reversed sample order for the FFT.
- Streams samples out on a valid/ready interface with full backpressure support.
- Sits between the sample RAM read port and the FFT/tuner datapath.

Parameters:
- DEPTH, 1024, samples per frame; power of two.
- ADDR_W, 11, RAM address width; must be >= log2(DEPTH)+1.
- DATA_W, 10, sample width.
- RD_LAT, 1, RAM read latency in cycles; legal values 1 or 2.

Ports:
- clk_100  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: begin a capture+read frame; ignored unless IDLE.
- req  out  1  capture request to the capture block; level signal.
- buf_ready  in  1  one-cycle pulse from the capture block: frame written.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  ADDR_W  RAM read address.
- rd_data  in  DATA_W  RAM read data, valid RD_LAT cycles after rd_en.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_W  output sample.
- m_last  out  1  high with the sample at address DEPTH-1.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last output handshake.

Behaviour:
- Interface: one clock, clk_100; reset is asynchronous and active-high, port rst.
- Reset values: req=0, rd_en=0, rd_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, frame_done=0. FSM to IDLE; skid FIFO emptied; in-flight counter cleared.
- Reset mid-frame: all in-flight RAM data is discarded. No output handshake occurs after reset deasserts until a new frame is started.
- FSM states: IDLE, REQ, READ, DRAIN, DONE.
- IDLE -> REQ on start.
- REQ: req=1 and held. On buf_ready: req<=0, rd_addr<=0, go to READ.
- REQ, buf_ready in the same cycle as entry: accepted.
- READ: issue rd_en=1 when (fifo_count + inflight) < RD_LAT+1.
  - rd_addr increments after each issue.
  - After issuing address DEPTH-1, go to DRAIN. No further rd_en; rd_addr stays at DEPTH-1.
- Data path:
  - Data returns RD_LAT cycles after issue via an rd_en delay line and is pushed into an internal FIFO of depth RD_LAT+1.
  - The FIFO never overflows, by the issue rule above.
  - The FIFO head drives m_data and m_valid.
  - The last tag is carried per entry through the delay line and FIFO and drives m_last.
- Handshake:
  - Transfer occurs when m_valid && m_ready.
  - m_data, m_valid and m_last remain stable while m_valid && !m_ready.
  - A simultaneous push and pop leaves fifo_count unchanged.
- Throughput: with m_ready held high, one sample per cycle after an initial RD_LAT+1 cycle latency from READ entry. Total DEPTH output beats.
- DRAIN -> DONE on the transfer with m_last=1.
- DONE: frame_done=1 for one cycle, then go to IDLE.
- start while not IDLE: ignored.
- buf_ready outside REQ: ignored.
- Counters: issue counter is log2(DEPTH)+1 bits; no wrap within a frame. inflight is 0..RD_LAT.

Optional Feature:
- Macro: SAMPLE_BUF_AUTO_REARM_EN.
- Defined: DONE goes directly to REQ, issuing a new capture request without start; start remains usable from IDLE only. frame_done still pulses.
- Undefined: DONE -> IDLE. Each frame requires a start pulse.

Decomposition:
- Shared package audio_pkg holds:
  - typedef enum rd_state_t {IDLE, REQ, READ, DRAIN, DONE};
  - localparams SAMPLE_DEPTH=1024, SAMPLE_W=10, SAMPLE_ADDR_W=11.
- One sub-module: sample_skid_fifo (parameterised depth/width, push/pop/count, data+last). The FSM stays in the top module.

Test Plan:
- Reset, then start pulse -> req rises the next cycle and stays high. After buf_ready (pulsed 50 cycles later): req falls, first rd_en with rd_addr=0 next cycle.
- RAM preloaded with data=addr[9:0], m_ready=1 -> 1024 beats, m_data 0..1023 in order, m_last only on 1023, frame_done one cycle after, busy=0 after that.
- m_ready toggled 1-0-0-1 pseudo-randomly, RD_LAT=2 -> no lost or duplicated samples, m_data stable during stalls, never more than 3 outstanding.
- rst asserted at output beat 500, released 10 cycles later -> all outputs 0 immediately (async), no m_valid until next start. Next frame delivers samples from 0.
- start during READ and buf_ready during IDLE -> no state change, sample sequence unaffected.
- SAMPLE_BUF_AUTO_REARM_EN defined -> req re-asserts the cycle after the frame_done pulse without start. Two back-to-back frames of 1024 beats each.

Source files
------------

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared sizes and read-FSM state type for the audio sample path
package audio_pkg;

  localparam int SAMPLE_DEPTH  = 1024;
  localparam int SAMPLE_W      = 10;
  localparam int SAMPLE_ADDR_W = 11;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    READ,
    DRAIN,
    DONE
  } rd_state_t;

endpackage

// File: rtl/sample_skid_fifo.sv
// rtl/sample_skid_fifo.sv - small skid FIFO holding returned RAM samples plus their last tag
module sample_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 10
) (
  input  logic                           clk_100,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           push_last,
  input  logic                           pop,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           head_valid,
  output logic [WIDTH-1:0]               head_data,
  output logic                           head_last
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0] last_mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  // Pointers wrap at DEPTH (not necessarily a power of two); count tracks occupancy.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage needs no reset: only entries below count are ever exposed.
  always_ff @(posedge clk_100) begin
    if (push) begin
      data_mem[wr_ptr] <= push_data;
      last_mem[wr_ptr] <= push_last;
    end
  end

  assign count      = cnt;
  assign head_valid = (cnt != '0);
  assign head_data  = head_valid ? data_mem[rd_ptr] : '0;
  assign head_last  = head_valid & last_mem[rd_ptr];

endmodule

// File: rtl/sample_buf_reader.sv
// rtl/sample_buf_reader.sv - requests a capture, then streams the sample RAM out; SAMPLE_BUF_AUTO_REARM_EN rearms after each frame
module sample_buf_reader
  import audio_pkg::*;
#(
  parameter int DEPTH  = SAMPLE_DEPTH,
  parameter int ADDR_W = SAMPLE_ADDR_W,
  parameter int DATA_W = SAMPLE_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              start,
  output logic              req,
  input  logic              buf_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W      = $clog2(DEPTH) + 1;
  localparam int FIFO_DEPTH = RD_LAT + 1;
  localparam int FCNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W      = FCNT_W + 1;

  rd_state_t         state;
  rd_state_t         state_nxt;
  logic [CNT_W-1:0]  issue_cnt;
  logic              issue;
  logic              issue_last;
  logic [RD_LAT-1:0] vld_pipe;
  logic [RD_LAT-1:0] last_pipe;
  logic [FCNT_W-1:0] inflight;
  logic [FCNT_W-1:0] fifo_count;
  logic [OCC_W-1:0]  occupancy;
  logic              push;
  logic              push_last;
  logic              pop;

  assign pop        = m_valid & m_ready;
  assign push       = vld_pipe[RD_LAT-1];
  assign push_last  = last_pipe[RD_LAT-1];
  assign issue_last = (issue_cnt == CNT_W'(DEPTH-1));

  // Outstanding samples (queued + in the RAM pipe); the slot freed by this
  // cycle's pop is credited so a continuously ready sink sees one beat per cycle
  // while the FIFO still can never receive more than FIFO_DEPTH entries.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight) - OCC_W'(pop);
  assign issue     = (state == READ) && (occupancy < OCC_W'(FIFO_DEPTH));
  assign rd_addr   = ADDR_W'(issue_cnt);

  // State register.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: frame sequencing from request through drain of the last beat.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     if (buf_ready) state_nxt = READ;
      READ:    if (issue && issue_last) state_nxt = DRAIN;
      DRAIN:   if (pop && m_last) state_nxt = DONE;
`ifdef SAMPLE_BUF_AUTO_REARM_EN
      DONE:    state_nxt = REQ;
`else
      DONE:    state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    req        = (state == REQ);
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    rd_en      = issue;
  end

  // Read address counter: cleared on frame acceptance, parked at DEPTH-1 after the last issue.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
    end else if ((state == REQ) && buf_ready) begin
      issue_cnt <= '0;
    end else if (issue && !issue_last) begin
      issue_cnt <= issue_cnt + 1'b1;
    end
  end

  // RAM latency delay line carrying valid and last tag, plus the in-flight count.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      inflight  <= '0;
    end else begin
      vld_pipe[0]  <= issue;
      last_pipe[0] <= issue & issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
      inflight <= inflight + FCNT_W'(issue) - FCNT_W'(push);
    end
  end

  sample_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_skid (
    .clk_100    (clk_100),
    .rst        (rst),
    .push       (push),
    .push_data  (rd_data),
    .push_last  (push_last),
    .pop        (pop),
    .count      (fifo_count),
    .head_valid (m_valid),
    .head_data  (m_data),
    .head_last  (m_last)
  );

endmodule
